// File: rtl/alu_seq_nbit_if.sv
// Operand/result bundle between the control FSM (master) and the sequential ALU (slave).
// A start pulse carries op and operands; done marks a fresh result and flag set.
interface alu_seq_nbit_if #(parameter int N = 8);
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] alu_out;
  logic         Z;
  logic         N_f;
  logic         C;
  logic         V;
  logic         ill;

  modport master (
    output start, op, in0, in1, c_in,
    input  busy, done, alu_out, Z, N_f, C, V, ill
  );

  modport slave (
    input  start, op, in0, in1, c_in,
    output busy, done, alu_out, Z, N_f, C, V, ill
  );
endinterface

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with Z/N/C/V/ill flags; 1-cycle latency, N-cycle shift-add MUL when ALU_MUL_EN is defined.
// start is honoured only in IDLE; a start while busy is dropped, never queued.
module alu_seq_nbit #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_nbit_if.slave io
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_ORN  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_ANDN = 4'd5;
  localparam logic [3:0] OP_NOTA = 4'd6;
  localparam logic [3:0] OP_NOTB = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam int         CW      = $clog2(N);
`endif

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t       state_q;
  logic [N-1:0] alu_out_q;
  logic         z_q, n_q, c_q, v_q, ill_q, done_q;

  logic [N-1:0] res_d;
  logic         c_d, v_d, ill_d;
  logic [N:0]   add_s;
  logic [N-1:0] bx_s;

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    ill_d = 1'b0;
    add_s = '0;
    bx_s  = '0;
    case (io.op)
      OP_ADD, OP_SUB: begin
        bx_s  = (io.op == OP_SUB) ? ~io.in1 : io.in1;
        add_s = {1'b0, io.in0} + {1'b0, bx_s}
              + {{N{1'b0}}, (io.op == OP_SUB) ? 1'b1 : io.c_in};
        res_d = add_s[N-1:0];
        c_d   = add_s[N];
        // Same-sign operands producing an opposite-sign result == carry-in(MSB) ^ carry-out(MSB)
        v_d   = (io.in0[N-1] == bx_s[N-1]) && (add_s[N-1] != io.in0[N-1]);
      end
      OP_OR:   res_d = io.in0 | io.in1;
      OP_ORN:  res_d = io.in0 | ~io.in1;
      OP_AND:  res_d = io.in0 & io.in1;
      OP_ANDN: res_d = io.in0 & ~io.in1;
      OP_NOTA: res_d = ~io.in0;
      OP_NOTB: res_d = ~io.in1;
      OP_SHL: begin
        res_d = {io.in0[N-2:0], 1'b0};
        c_d   = io.in0[N-1];
      end
      OP_SHR: begin
        res_d = {1'b0, io.in0[N-1:1]};
        c_d   = io.in0[0];
      end
      OP_ASR: begin
        res_d = {io.in0[N-1], io.in0[N-1:1]};
        c_d   = io.in0[0];
      end
      default: ill_d = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  mcand_q;
  logic [N-1:0]    mplier_q;
  logic [2*N-1:0]  prod_q;
  logic [2*N-1:0]  prod_d;

  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      alu_out_q <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (io.start) begin
`ifdef ALU_MUL_EN
            if (io.op == OP_MUL) begin
              state_q  <= S_MUL;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              mcand_q  <= {{N{1'b0}}, io.in0};
              mplier_q <= io.in1;
              prod_q   <= '0;
            end else
`endif
            begin
              alu_out_q <= res_d;
              z_q       <= (res_d == '0);
              n_q       <= res_d[N-1];
              c_q       <= c_d;
              v_q       <= v_d;
              ill_q     <= ill_d;
              done_q    <= 1'b1;
            end
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[2*N-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[N-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            alu_out_q <= prod_d[N-1:0];
            z_q       <= (prod_d[N-1:0] == '0);
            n_q       <= prod_d[N-1];
            c_q       <= |prod_d[2*N-1:N];
            v_q       <= |prod_d[2*N-1:N];
            ill_q     <= 1'b0;
            done_q    <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.alu_out = alu_out_q;
  assign io.Z       = z_q;
  assign io.N_f     = n_q;
  assign io.C       = c_q;
  assign io.V       = v_q;
  assign io.ill     = ill_q;
  assign io.done    = done_q;
`ifdef ALU_MUL_EN
  assign io.busy    = busy_q;
`else
  assign io.busy    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit at N=8; MUL expectations follow ALU_MUL_EN.
module tb_alu_seq_nbit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_seq_nbit_if #(.N(8)) if0 ();

  alu_seq_nbit #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (if0.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic st, input logic [3:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic ci);
    if0.start = st;
    if0.op    = o;
    if0.in0   = a;
    if0.in1   = b;
    if0.c_in  = ci;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed as {done, busy, alu_out[7:0], Z, N_f, C, V, ill}
  task automatic expect_st(input string tag, input logic d, input logic bz, input logic [7:0] out,
                           input logic z, input logic n, input logic c, input logic v, input logic il);
    logic [14:0] obs;
    logic [14:0] exp;
    obs = {if0.done, if0.busy, if0.alu_out, if0.Z, if0.N_f, if0.C, if0.V, if0.ill};
    exp = {d, bz, out, z, n, c, v, il};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={done,busy,out,Z,N,C,V,ill}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    expect_st("reset", 0, 0, 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;

    drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0);
    step();
    expect_st("add_ovf", 1, 0, 8'h80, 0, 1, 0, 1, 0);

    drive(1'b1, 4'd1, 8'h05, 8'h05, 1'b0);
    step();
    expect_st("sub_zero", 1, 0, 8'h00, 1, 0, 1, 0, 0);
    drive(1'b1, 4'd0, 8'hFF, 8'h00, 1'b1);
    step();
    expect_st("add_cin_wrap", 1, 0, 8'h00, 1, 0, 1, 0, 0);
    drive(1'b0, 4'd2, 8'h12, 8'h34, 1'b0);
    step();
    expect_st("hold_idle", 0, 0, 8'h00, 1, 0, 1, 0, 0);

    drive(1'b1, 4'd8, 8'h81, 8'h00, 1'b0);
    step();
    expect_st("shl", 1, 0, 8'h02, 0, 0, 1, 0, 0);
    drive(1'b1, 4'd10, 8'h81, 8'h00, 1'b0);
    step();
    expect_st("asr", 1, 0, 8'hC0, 0, 1, 1, 0, 0);
    drive(1'b1, 4'd9, 8'h81, 8'h00, 1'b0);
    step();
    expect_st("shr", 1, 0, 8'h40, 0, 0, 1, 0, 0);

    drive(1'b1, 4'd2, 8'hF0, 8'h0C, 1'b0);
    step();
    expect_st("or", 1, 0, 8'hFC, 0, 1, 0, 0, 0);
    drive(1'b1, 4'd3, 8'h00, 8'hF0, 1'b0);
    step();
    expect_st("orn", 1, 0, 8'h0F, 0, 0, 0, 0, 0);
    drive(1'b1, 4'd4, 8'hF0, 8'h3C, 1'b0);
    step();
    expect_st("and", 1, 0, 8'h30, 0, 0, 0, 0, 0);
    drive(1'b1, 4'd5, 8'hF0, 8'h3C, 1'b0);
    step();
    expect_st("andn", 1, 0, 8'hC0, 0, 1, 0, 0, 0);
    drive(1'b1, 4'd6, 8'h55, 8'h00, 1'b0);
    step();
    expect_st("nota", 1, 0, 8'hAA, 0, 1, 0, 0, 0);
    drive(1'b1, 4'd7, 8'h55, 8'hFF, 1'b0);
    step();
    expect_st("notb", 1, 0, 8'h00, 1, 0, 0, 0, 0);

    drive(1'b1, 4'd10, 8'h81, 8'h00, 1'b0);
    step();
    expect_st("asr_pre_ill", 1, 0, 8'hC0, 0, 1, 1, 0, 0);
    drive(1'b1, 4'd13, 8'h81, 8'h81, 1'b1);
    step();
    expect_st("illegal13", 1, 0, 8'h00, 1, 0, 0, 0, 1);
    drive(1'b1, 4'd4, 8'hFF, 8'hFF, 1'b0);
    step();
    expect_st("ill_clear", 1, 0, 8'hFF, 0, 1, 0, 0, 0);

`ifdef ALU_MUL_EN
    drive(1'b1, 4'd11, 8'd15, 8'd17, 1'b0);
    step();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    expect_st("mul_busy_k", 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0);
      step();
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      expect_st($sformatf("mul_busy_%0d", i), 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    end
    step();
    expect_st("mul_15x17", 1, 0, 8'hFF, 0, 1, 0, 0, 0);
    step();
    expect_st("mul_after", 0, 0, 8'hFF, 0, 1, 0, 0, 0);

    drive(1'b1, 4'd11, 8'd16, 8'd16, 1'b0);
    step();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i < 8; i++) step();
    expect_st("mul16_busy_last", 0, 1, 8'hFF, 0, 1, 0, 0, 0);
    step();
    expect_st("mul_16x16", 1, 0, 8'h00, 1, 0, 1, 1, 0);

    drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0);
    step();
    expect_st("add_pre_rst", 1, 0, 8'h80, 0, 1, 0, 1, 0);
    drive(1'b1, 4'd11, 8'd3, 8'd3, 1'b0);
    step();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_st("mul_mid_rst", 0, 0, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_st($sformatf("mul_rst_quiet_%0d", i), 0, 0, 8'h00, 0, 0, 0, 0, 0);
    end
`else
    drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0);
    step();
    expect_st("add_pre_mul", 1, 0, 8'h80, 0, 1, 0, 1, 0);
    drive(1'b1, 4'd11, 8'd3, 8'd5, 1'b0);
    step();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    expect_st("mul_disabled", 1, 0, 8'h00, 1, 0, 0, 0, 1);
    step();
    expect_st("mul_disabled_idle", 0, 0, 8'h00, 1, 0, 0, 0, 1);
    drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0);
    step();
    expect_st("add_pre_rst", 1, 0, 8'h80, 0, 1, 0, 1, 0);
`endif

    rst = 1'b1;
    drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    expect_st("rst_wins", 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step();
    expect_st("rst_wins_next", 0, 0, 8'h00, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
